// File: rtl/dcache_lite_pkg.sv
// Shared definitions for the L1 data cache: FSM states, default geometry and the latched request.
package cpu_defs;

    localparam int unsigned DCACHE_SETS       = 64;
    localparam int unsigned DCACHE_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        REFILL,
        WR_REQ,
        WR_WAIT,
        DONE
    } dcache_state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dcache_req_t;

endpackage

// File: rtl/dcache_lite_array.sv
// Tag/valid/data storage for dcache_lite: asynchronous read, byte-strobed word write,
// tag+valid install, valid bits cleared by asynchronous reset.
module dcache_array
    import cpu_defs::*;
#(
    parameter int unsigned SETS       = DCACHE_SETS,
    parameter int unsigned LINE_WORDS = DCACHE_LINE_WORDS,
    parameter int unsigned TAG_W      = 32 - $clog2(SETS) - $clog2(LINE_WORDS) - 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(SETS)-1:0]       idx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_off_i,
    output logic [31:0]                   rd_data_o,
    output logic [TAG_W-1:0]              rd_tag_o,
    output logic                          rd_valid_o,
    input  logic                          wr_en_i,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_off_i,
    input  logic [31:0]                   wr_data_i,
    input  logic [3:0]                    wr_strb_i,
    input  logic                          tag_we_i,
    input  logic [TAG_W-1:0]              tag_i
);

    logic [31:0]      data_q [SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [SETS-1:0]  valid_q;

    assign rd_data_o  = data_q[{idx_i, rd_off_i}];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_valid_o = valid_q[idx_i];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_strb_i[b]) begin
                    data_q[{idx_i, wr_off_i}][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we_i) begin
            tag_q[idx_i] <= tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_lite.sv
// Blocking direct-mapped write-through no-write-allocate L1 data cache.
// Optional hit/miss counters enabled by defining DCACHE_PERF_CNT_EN.
module dcache_lite
    import cpu_defs::*;
#(
    parameter int unsigned SETS       = DCACHE_SETS,
    parameter int unsigned LINE_WORDS = DCACHE_LINE_WORDS,
    parameter int unsigned TAG_W      = 32 - $clog2(SETS) - $clog2(LINE_WORDS) - 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic        req_stall,
    input  logic        req_flush,
    output logic        dcache_ready,
    output logic [31:0] rd_dcache_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_len,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rlast,
    input  logic        mem_bvalid
`ifdef DCACHE_PERF_CNT_EN
   ,output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);

    dcache_state_t state_q, state_d;
    dcache_req_t   req_q, req_d;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic [31:0]      crit_q, crit_d;
    logic             flushed_q, flushed_d;

    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      arr_rd_data;
    logic [TAG_W-1:0] arr_tag;
    logic             arr_valid;
    logic             hit;
    logic             arr_wr_en;
    logic [OFF_W-1:0] arr_wr_off;
    logic [31:0]      arr_wr_data;
    logic [3:0]       arr_wr_strb;
    logic             arr_tag_we;
    logic             can_accept;

    assign req_idx = req_q.addr[OFF_W+2 +: IDX_W];
    assign req_off = req_q.addr[OFF_W+1:2];
    assign req_tag = req_q.addr[31 -: TAG_W];
    assign hit     = arr_valid && (arr_tag == req_tag);

    dcache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx_i      (req_idx),
        .rd_off_i   (req_off),
        .rd_data_o  (arr_rd_data),
        .rd_tag_o   (arr_tag),
        .rd_valid_o (arr_valid),
        .wr_en_i    (arr_wr_en),
        .wr_off_i   (arr_wr_off),
        .wr_data_i  (arr_wr_data),
        .wr_strb_i  (arr_wr_strb),
        .tag_we_i   (arr_tag_we),
        .tag_i      (req_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            beat_q    <= '0;
            crit_q    <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            beat_q    <= beat_d;
            crit_q    <= crit_d;
            flushed_q <= flushed_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        beat_d         = beat_q;
        crit_d         = crit_q;
        flushed_d      = flushed_q;
        dcache_ready   = 1'b1;
        rd_dcache_data = '0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_len        = '0;
        mem_wdata      = '0;
        mem_wstrb      = '0;
        arr_wr_en      = 1'b0;
        arr_wr_off     = req_off;
        arr_wr_data    = req_q.wdata;
        arr_wr_strb    = req_q.wstrb;
        arr_tag_we     = 1'b0;
        can_accept     = 1'b0;

        case (state_q)
            IDLE: can_accept = 1'b1;
            LOOKUP: begin
                if (req_flush) begin
                    state_d    = IDLE;
                    can_accept = 1'b1;
                end else if (!req_q.wr) begin
                    if (hit) begin
                        rd_dcache_data = arr_rd_data;
                        state_d        = IDLE;
                        can_accept     = 1'b1;
                    end else begin
                        dcache_ready = 1'b0;
                        beat_d       = '0;
                        flushed_d    = 1'b0;
                        state_d      = MISS;
                    end
                end else begin
                    dcache_ready = 1'b0;
                    arr_wr_en    = hit;
                    state_d      = WR_REQ;
                end
            end
            MISS: begin
                dcache_ready = 1'b0;
                mem_req      = 1'b1;
                mem_addr     = {req_q.addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                mem_len      = 8'(LINE_WORDS - 1);
                // A flush that coincides with gnt cannot cancel the burst; let it drain.
                if (mem_gnt) begin
                    flushed_d = req_flush;
                    state_d   = REFILL;
                end else if (req_flush) begin
                    state_d = IDLE;
                end
            end
            REFILL: begin
                dcache_ready = 1'b0;
                flushed_d    = flushed_q | req_flush;
                if (mem_rvalid) begin
                    arr_wr_en   = 1'b1;
                    arr_wr_off  = beat_q;
                    arr_wr_data = mem_rdata;
                    arr_wr_strb = 4'hF;
                    beat_d      = beat_q + 1'b1;
                    if (beat_q == req_off) begin
                        crit_d = mem_rdata;
                    end
                    if (mem_rlast) begin
                        arr_tag_we = 1'b1;
                        state_d    = flushed_d ? IDLE : DONE;
                    end
                end
            end
            WR_REQ: begin
                dcache_ready = 1'b0;
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = req_q.addr;
                mem_wdata    = req_q.wdata;
                mem_wstrb    = req_q.wstrb;
                if (mem_gnt) begin
                    state_d = WR_WAIT;
                end else if (req_flush) begin
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                dcache_ready = 1'b0;
                if (mem_bvalid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rd_dcache_data = crit_q;
                state_d        = IDLE;
                can_accept     = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (can_accept && req_valid && !req_stall) begin
            req_d.wr    = req_wr;
            req_d.addr  = req_addr;
            req_d.wdata = req_wdata;
            req_d.wstrb = req_wstrb;
            crit_d      = '0;
            state_d     = LOOKUP;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP && !req_flush) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_lite.sv
// Directed self-checking bench for dcache_lite; the bench itself plays the memory bus.
module tb_dcache_lite;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_wr, req_stall, req_flush;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        dcache_ready;
    logic [31:0] rd_dcache_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  mem_len;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid, mem_rlast, mem_bvalid;
    logic [31:0] mem_rdata;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    dcache_lite dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .req_stall      (req_stall),
        .req_flush      (req_flush),
        .dcache_ready   (dcache_ready),
        .rd_dcache_data (rd_dcache_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_len        (mem_len),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .mem_rlast      (mem_rlast),
        .mem_bvalid     (mem_bvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Present one request for a cycle; returns #1 into the LOOKUP cycle with flush applied.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic flush);
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        @(negedge clk);
        req_valid = 1'b0; req_flush = flush;
        #1;
    endtask

    // Deliver a 4-beat burst base+i; optionally pulse req_flush on one beat.
    task automatic refill(input logic [31:0] base, input int flush_beat);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = base + 32'(i);
            mem_rlast = (i == 3); req_flush = (i == flush_beat);
            #1;
            chk("refill_ready", {31'd0, dcache_ready}, 32'd0);
        end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = '0; req_flush = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; req_stall = 1'b0; req_flush = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0; mem_bvalid = 1'b0;
        #1;
        chk("rst_ready", {31'd0, dcache_ready}, 32'd1);
        chk("rst_rdata", rd_dcache_data, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_len", {24'd0, mem_len}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Cold load miss at 0x1008
        issue(1'b0, 32'h0000_1008, '0, '0, 1'b0);
        chk("cold_lookup_ready", {31'd0, dcache_ready}, 32'd0);
        chk("cold_lookup_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk); #1;
        chk("miss_mem_req", {31'd0, mem_req}, 32'd1);
        chk("miss_mem_we", {31'd0, mem_we}, 32'd0);
        chk("miss_mem_addr", mem_addr, 32'h0000_1000);
        chk("miss_mem_len", {24'd0, mem_len}, 32'd3);
        chk("miss_ready", {31'd0, dcache_ready}, 32'd0);
        @(negedge clk); mem_gnt = 1'b1; #1;
        chk("miss_addr_hold", mem_addr, 32'h0000_1000);
        chk("miss_req_hold", {31'd0, mem_req}, 32'd1);
        refill(32'hA0, 99);
        chk("cold_done_ready", {31'd0, dcache_ready}, 32'd1);
        chk("cold_done_data", rd_dcache_data, 32'hA2);

        // Back-to-back hits
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_1000;
        @(negedge clk); req_addr = 32'h0000_1004; #1;
        chk("b2b0_ready", {31'd0, dcache_ready}, 32'd1);
        chk("b2b0_data", rd_dcache_data, 32'hA0);
        chk("b2b0_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk); req_addr = 32'h0000_100C; #1;
        chk("b2b1_ready", {31'd0, dcache_ready}, 32'd1);
        chk("b2b1_data", rd_dcache_data, 32'hA1);
        @(negedge clk); req_valid = 1'b0; #1;
        chk("b2b2_ready", {31'd0, dcache_ready}, 32'd1);
        chk("b2b2_data", rd_dcache_data, 32'hA3);
        chk("b2b2_mem_req", {31'd0, mem_req}, 32'd0);

        // Store hit with partial strobes
        issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0011, 1'b0);
        chk("st_lookup_ready", {31'd0, dcache_ready}, 32'd0);
        @(negedge clk); mem_gnt = 1'b1; #1;
        chk("st_mem_req", {31'd0, mem_req}, 32'd1);
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_addr", mem_addr, 32'h0000_1004);
        chk("st_mem_len", {24'd0, mem_len}, 32'd0);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_mem_wstrb", {28'd0, mem_wstrb}, 32'h3);
        @(negedge clk); mem_gnt = 1'b0; #1;
        chk("st_wait_ready", {31'd0, dcache_ready}, 32'd0);
        chk("st_wait_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk); mem_bvalid = 1'b1; #1;
        chk("st_bvalid_ready", {31'd0, dcache_ready}, 32'd0);
        @(negedge clk); mem_bvalid = 1'b0; #1;
        chk("st_done_ready", {31'd0, dcache_ready}, 32'd1);
        chk("st_done_data", rd_dcache_data, 32'd0);
        issue(1'b0, 32'h0000_1004, '0, '0, 1'b0);
        chk("merge_ready", {31'd0, dcache_ready}, 32'd1);
        chk("merge_data", rd_dcache_data, 32'h0000_BEEF);

        // Store miss: write-through, no allocate
        issue(1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 1'b0);
        chk("sm_lookup_ready", {31'd0, dcache_ready}, 32'd0);
        @(negedge clk); mem_gnt = 1'b1; #1;
        chk("sm_mem_addr", mem_addr, 32'h0000_2000);
        chk("sm_mem_we", {31'd0, mem_we}, 32'd1);
        @(negedge clk); mem_gnt = 1'b0; mem_bvalid = 1'b1;
        @(negedge clk); mem_bvalid = 1'b0; #1;
        chk("sm_done_ready", {31'd0, dcache_ready}, 32'd1);
        issue(1'b0, 32'h0000_2000, '0, '0, 1'b0);
        chk("na_lookup_ready", {31'd0, dcache_ready}, 32'd0);
        @(negedge clk); mem_gnt = 1'b1; #1;
        chk("na_mem_req", {31'd0, mem_req}, 32'd1);
        chk("na_mem_addr", mem_addr, 32'h0000_2000);
        refill(32'hB0, 99);
        chk("na_done_data", rd_dcache_data, 32'hB0);

        // Flush in LOOKUP of a load miss (0x1000 line was evicted by 0x2000)
        issue(1'b0, 32'h0000_1008, '0, '0, 1'b1);
        chk("fl_lookup_ready", {31'd0, dcache_ready}, 32'd1);
        chk("fl_lookup_mem_req", {31'd0, mem_req}, 32'd0);
        chk("fl_lookup_data", rd_dcache_data, 32'd0);
        @(negedge clk); req_flush = 1'b0; #1;
        chk("fl_idle_mem_req", {31'd0, mem_req}, 32'd0);

        // Flush after gnt: line completes, no response
        issue(1'b0, 32'h0000_1008, '0, '0, 1'b0);
        chk("fr_lookup_ready", {31'd0, dcache_ready}, 32'd0);
        @(negedge clk); mem_gnt = 1'b1; #1;
        chk("fr_mem_req", {31'd0, mem_req}, 32'd1);
        refill(32'hA0, 1);
        chk("fr_end_ready", {31'd0, dcache_ready}, 32'd1);
        chk("fr_end_data", rd_dcache_data, 32'd0);
        issue(1'b0, 32'h0000_1008, '0, '0, 1'b0);
        chk("fr_hit_ready", {31'd0, dcache_ready}, 32'd1);
        chk("fr_hit_data", rd_dcache_data, 32'hA2);

        // Reset in the middle of a refill
        issue(1'b0, 32'h0000_3000, '0, '0, 1'b0);
        chk("rr_lookup_ready", {31'd0, dcache_ready}, 32'd0);
        @(negedge clk); mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hC0;
        @(negedge clk); mem_rdata = 32'hC1; #1;
        chk("rr_refill_ready", {31'd0, dcache_ready}, 32'd0);
        @(negedge clk); mem_rvalid = 1'b0; mem_rdata = '0; rst_n = 1'b0; #1;
        chk("rr_rst_ready", {31'd0, dcache_ready}, 32'd1);
        chk("rr_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rr_rst_data", rd_dcache_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        issue(1'b0, 32'h0000_1008, '0, '0, 1'b0);
        chk("rr_after_lookup_ready", {31'd0, dcache_ready}, 32'd0);
        @(negedge clk); #1;
        chk("rr_after_mem_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk); req_flush = 1'b1; #1;
        chk("ab_miss_mem_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk); req_flush = 1'b0; #1;
        chk("ab_idle_mem_req", {31'd0, mem_req}, 32'd0);
        chk("ab_idle_ready", {31'd0, dcache_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcache_lite.md
Name: dcache_lite

Overview:
- Blocking, direct-mapped, write-through, no-write-allocate L1 data cache.
- Sits between the Memory1 stage, which issues requests, and the Memory2 stage, which consumes dcache_ready/rd_dcache_data.
- Returns the full aligned 32-bit word; byte/half extraction and sign extension stay in Memory2.
- Misses and all stores go to a simple burst memory bus.

Parameters:
- SETS, 64, number of lines (power of 2).
- LINE_WORDS, 4, 32-bit words per line (power of 2).
- TAG_W, 32-log2(SETS)-log2(LINE_WORDS)-2, derived tag width (22 by default).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  Memory1 has a load/store
- req_wr  in  1  1=store, 0=load
- req_addr  in  32  byte address, word-aligned
- req_wdata  in  32  store data
- req_wstrb  in  4  store byte enables
- req_stall  in  1  pipeline stall; request not accepted
- req_flush  in  1  Memory2 instruction squashed
- dcache_ready  out  1  response for previously accepted request valid
- rd_dcache_data  out  32  load data word
- mem_req  out  1  memory request valid
- mem_we  out  1  write request
- mem_addr  out  32  line-aligned (read) or word address (write)
- mem_len  out  8  beats-1
- mem_wdata  out  32  write data
- mem_wstrb  out  4  write strobes
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  32  read beat
- mem_rlast  in  1  last read beat
- mem_bvalid  in  1  write complete

Behaviour:
- Reset (async): state IDLE; all valid bits 0; dcache_ready=1, rd_dcache_data=0, mem_req=0, mem_we=0, other mem_* outputs 0. Reset mid-refill or mid-write abandons the transaction immediately.
- Accept: req_valid & ~req_stall while in IDLE, LOOKUP-hit or DONE. Latch addr/wr/wdata/wstrb; next state LOOKUP.
- LOOKUP, flushed (req_flush=1): request dropped, no array or memory update, dcache_ready=1, next state IDLE or LOOKUP on a new accept.
- LOOKUP, load hit: dcache_ready=1, rd_dcache_data=array word, same cycle. Back-to-back hits sustain one request per cycle.
- LOOKUP, load miss: dcache_ready=0, next state MISS.
- LOOKUP, store: on a hit, bytes merge into the line per wstrb; on a miss, no allocate. dcache_ready=0, next state WR_REQ.
- MISS: mem_req=1, mem_we=0, mem_addr=line base, mem_len=LINE_WORDS-1. Move to REFILL on mem_gnt. req_flush before gnt aborts to IDLE.
- REFILL:
  - Beat counter (log2 LINE_WORDS bits, from 0) writes each mem_rvalid beat into the line.
  - The beat whose index equals the request offset is captured as the critical word.
  - On mem_rlast: tag written, valid=1, next state DONE.
  - req_flush during REFILL: the line still completes, the response is discarded, next state IDLE.
- WR_REQ: mem_req=1, mem_we=1, mem_addr=req word address, mem_len=0, wdata/wstrb as latched. Move to WR_WAIT on gnt. req_flush before gnt aborts.
- WR_WAIT: wait for mem_bvalid, then DONE.
- DONE: dcache_ready=1; rd_dcache_data=captured word (0 for stores). Accepts a new request; otherwise next state IDLE.
- IDLE: dcache_ready=1, rd_dcache_data=0.
- dcache_ready=0 only in MISS, REFILL, WR_REQ, WR_WAIT, and LOOKUP-miss/store.
- mem_req stays asserted until gnt, with outputs stable.
- mem_rvalid outside REFILL and mem_bvalid outside WR_WAIT are ignored.

Optional Feature:
- DCACHE_PERF_CNT_EN defined: adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
  - Counted in LOOKUP for unflushed requests: load hit, or store hit → hit; otherwise → miss.
  - Counters wrap at 2^32 and reset to 0.
- Not defined: counters and ports absent; behaviour otherwise identical.

Decomposition:
- Shared package (cpu_defs) holds:
  - dcache_state_t enum: IDLE, LOOKUP, MISS, REFILL, WR_REQ, WR_WAIT, DONE.
  - Default SETS/LINE_WORDS constants.
  - A dcache_req_t struct (wr, addr, wdata, wstrb) for the latched request.
- One sub-module: dcache_array, holding the tag/valid/data storage.
  - Asynchronous read.
  - Writes: word write with byte strobes; tag+valid set.
  - Async valid clear on reset.

Test Plan:
- Cold load at 0x0000_1008 with memory holding 0xA0+i at word i → MISS, burst of 4 beats; DONE with rd_dcache_data=0xA2, dcache_ready low from the LOOKUP cycle until DONE.
- Back-to-back loads 0x1000, 0x1004, 0x100C after the fill → three consecutive ready=1 cycles returning 0xA0, 0xA1, 0xA3; no mem_req.
- Store 0x1004, wdata 0xDEADBEEF, wstrb 0b0011 → one write request with mem_len=0; ready low until bvalid. A following load of 0x1004 hits and returns 0x0000BEEF | (0xA1 & 0xFFFF0000).
- Store miss at 0x2000 → memory write issued; a subsequent load of 0x2000 misses (no allocate).
- Load miss with req_flush asserted in the LOOKUP cycle → no mem_req, ready=1. Flush after gnt → refill completes, the line becomes valid, and no response is returned.
- rst_n pulsed low mid-REFILL → outputs at reset values immediately; a subsequent load of the same line misses.
